// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: exception codes, reset vectors and
// the per-cycle stage operation decoded from the pipeline control inputs.
package mips_pipe_pkg;

    localparam int unsigned EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_PC = 32'h0000_4180;

    typedef enum logic [1:0] {
        OpFlush,
        OpHold,
        OpBubble,
        OpLoad
    } stage_op_e;

    // Reset is handled separately by the register itself; this covers the rest.
    function automatic stage_op_e stage_op(input logic flush, input logic stall,
                                           input logic bubble);
        if (flush) return OpFlush;
        if (stall) return OpHold;
        if (bubble) return OpBubble;
        return OpLoad;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with hold, bubble and flush control
// plus a saturating count of consecutive stalled cycles.
module pipe_stage_reg #(
    parameter int unsigned DATA_W            = 96,
    parameter int unsigned EXC_W             = mips_pipe_pkg::EXC_W,
    parameter logic [31:0] NOP_INSTR         = mips_pipe_pkg::NOP_INSTR,
    parameter logic [31:0] RESET_PC          = mips_pipe_pkg::RESET_PC,
    parameter bit          KEEP_PC_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              stall,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [EXC_W-1:0]  local_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_stall_cnt
);

    import mips_pipe_pkg::*;

    stage_op_e         op;
    logic [EXC_W-1:0]  merged_exc;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign op = stage_op(flush, stall, bubble);

    // An exception raised by an older stage outranks one found here.
    assign merged_exc = (in_exc != '0) ? in_exc : local_exc;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        data_d  = data_q;
        unique case (op)
            OpFlush: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                pc_d    = flush_pc;
                bd_d    = 1'b0;
                exc_d   = '0;
                data_d  = '0;
            end
            OpHold: ;
            OpBubble: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                // Keeping PC/BD lets a later exception still report a correct EPC.
                pc_d    = KEEP_PC_ON_BUBBLE ? in_pc : 32'h0;
                bd_d    = KEEP_PC_ON_BUBBLE ? in_bd : 1'b0;
                exc_d   = '0;
                data_d  = '0;
            end
            OpLoad: begin
                valid_d = in_valid;
                instr_d = in_valid ? in_instr : NOP_INSTR;
                pc_d    = in_pc;
                bd_d    = in_bd;
                exc_d   = in_valid ? merged_exc : '0;
                data_d  = in_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            data_q  <= data_d;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (flush | ~stall),
        .inc   (stall),
        .count (out_stall_cnt)
    );

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_bd    = bd_q;
    assign out_exc   = exc_q;
    assign out_data  = data_q;

endmodule
